// File: rtl/instr_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch : multicycle fetch stage (PC, imem req/ready handshake, IR)
// Rev 1.0
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_old,
    output logic        inst_valid,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc_nx, pc_old_nx, inst_nx, pend_target, pend_target_nx;
    logic        pending, pending_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            pc_old      <= RESET_PC;
            inst        <= NOP_INST;
            pending     <= 1'b0;
            pend_target <= 32'h0;
            imem_req    <= 1'b0;
            inst_valid  <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pc_old      <= pc_old_nx;
            inst        <= inst_nx;
            pending     <= pending_nx;
            pend_target <= pend_target_nx;
            imem_req    <= (state_nx == WAIT);
            inst_valid  <= (state_nx == DONE);
        end
    end

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        pc_old_nx      = pc_old;
        inst_nx        = inst;
        pending_nx     = pending;
        pend_target_nx = pend_target;
        case (state)
            IDLE: begin
                if (fetch_req) begin
                    if (pc[1:0] == 2'b00) begin
                        state_nx = WAIT;
                        // Fetch uses the current PC; the redirect waits for completion.
                        if (pc_load) begin
                            pending_nx     = 1'b1;
                            pend_target_nx = pc_target;
                        end
                    end else begin
                        state_nx = FAULT;
                        if (pc_load) pc_nx = pc_target;
                    end
                end else if (pc_load) begin
                    pc_nx = pc_target;
                end
            end
            WAIT: begin
                if (imem_ready) begin
                    inst_nx    = imem_rdata;
                    pc_old_nx  = pc;
                    pending_nx = 1'b0;
                    state_nx   = DONE;
                    if (pc_load)      pc_nx = pc_target;
                    else if (pending) pc_nx = pend_target;
                    else              pc_nx = pc + 32'd4;
                end else if (pc_load) begin
                    pending_nx     = 1'b1;
                    pend_target_nx = pc_target;
                end
            end
            DONE: begin
                state_nx = IDLE;
                if (pc_load) pc_nx = pc_target;
            end
            FAULT: begin
                if (pc_load && (pc_target[1:0] == 2'b00)) begin
                    pc_nx    = pc_target;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign imem_addr = pc;
    assign busy      = (state == WAIT);
    assign fault     = (state == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_fetch : directed stimulus with a transaction-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] inst, pc, pc_old;
    logic        inst_valid, busy, fault;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cnt  = 0;
    int val_cnt  = 0;

    instr_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .inst       (inst),
        .pc         (pc),
        .pc_old     (pc_old),
        .inst_valid (inst_valid),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks whether a fetch is outstanding, whether the
    // just-completed instruction is being presented, and any deferred redirect.
    logic [31:0] m_pc, m_pc_old, m_inst, m_redir;
    bit          m_inflight, m_present, m_faulted, m_has_redir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RESET_PC; m_pc_old = RESET_PC; m_inst = NOP_INST;
            m_inflight = 0; m_present = 0; m_faulted = 0; m_has_redir = 0; m_redir = 0;
        end else if (m_faulted) begin
            if (pc_load && pc_target[1:0] == 2'b00) begin
                m_pc = pc_target; m_faulted = 0;
            end
        end else if (m_inflight) begin
            if (imem_ready) begin
                m_inst = imem_rdata; m_pc_old = m_pc;
                m_pc = pc_load ? pc_target : (m_has_redir ? m_redir : m_pc + 32'd4);
                m_has_redir = 0; m_inflight = 0; m_present = 1;
            end else if (pc_load) begin
                m_has_redir = 1; m_redir = pc_target;
            end
        end else if (m_present) begin
            m_present = 0;
            if (pc_load) m_pc = pc_target;
        end else if (fetch_req) begin
            if (m_pc[1:0] != 2'b00) begin
                m_faulted = 1;
                if (pc_load) m_pc = pc_target;
            end else begin
                m_inflight = 1;
                if (pc_load) begin m_has_redir = 1; m_redir = pc_target; end
            end
        end else if (pc_load) begin
            m_pc = pc_target;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_imem_req",   {31'd0, imem_req},   {31'd0, m_inflight});
            check("cyc_imem_addr",  imem_addr,           m_pc);
            check("cyc_pc",         pc,                  m_pc);
            check("cyc_pc_old",     pc_old,              m_pc_old);
            check("cyc_inst",       inst,                m_inst);
            check("cyc_inst_valid", {31'd0, inst_valid}, {31'd0, m_present});
            check("cyc_busy",       {31'd0, busy},       {31'd0, m_inflight});
            check("cyc_fault",      {31'd0, fault},      {31'd0, m_faulted});
            if (imem_req)   req_cnt++;
            if (inst_valid) val_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    int r0, v0;

    initial begin
        // Reset values
        #12;
        check("rst_pc", pc, RESET_PC);
        check("rst_pc_old", pc_old, RESET_PC);
        check("rst_inst", inst, NOP_INST);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid_busy_fault", {29'd0, inst_valid, busy, fault}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Fetch from 0 with two wait cycles
        r0 = req_cnt; v0 = val_cnt;
        fetch_req = 1; step(); fetch_req = 0;
        check("t1_addr", imem_addr, 32'h0);
        step(); step();
        imem_ready = 1; imem_rdata = 32'h0050_0093; step(); imem_ready = 0;
        check("t1_valid", {31'd0, inst_valid}, 32'd1);
        check("t1_inst", inst, 32'h0050_0093);
        check("t1_pc", pc, 32'h4);
        check("t1_pc_old", pc_old, 32'h0);
        step();
        check("t1_req_cycles", req_cnt - r0, 32'd3);
        check("t1_valid_pulses", val_cnt - v0, 32'd1);

        // Zero-wait fetch from 4; next fetch_req accepted three edges later
        fetch_req = 1; step(); fetch_req = 0;
        imem_ready = 1; imem_rdata = 32'h0010_8113; step(); imem_ready = 0;
        step();
        check("t2_pc8", pc, 32'h8);

        // Redirect during WAIT at pc=8
        fetch_req = 1; step(); fetch_req = 0;
        pc_load = 1; pc_target = 32'h100; step(); pc_load = 0;
        check("t2_addr_held", imem_addr, 32'h8);
        step();
        imem_ready = 1; imem_rdata = 32'h1234_5678; step(); imem_ready = 0;
        check("t2_pc", pc, 32'h100);
        check("t2_pc_old", pc_old, 32'h8);
        step();
        fetch_req = 1; step(); fetch_req = 0;
        check("t2_next_addr", imem_addr, 32'h100);
        check("t2_next_req", {31'd0, imem_req}, 32'd1);
        imem_ready = 1; imem_rdata = 32'hAAAA_0001; step(); imem_ready = 0;
        step();

        // Simultaneous fetch_req and pc_load in IDLE
        pc_load = 1; pc_target = 32'h20; step(); pc_load = 0;
        check("t3_pc20", pc, 32'h20);
        fetch_req = 1; pc_load = 1; pc_target = 32'h40; step();
        fetch_req = 0; pc_load = 0;
        check("t3_addr", imem_addr, 32'h20);
        imem_ready = 1; imem_rdata = 32'hBBBB_0002; step(); imem_ready = 0;
        check("t3_pc", pc, 32'h40);
        check("t3_pc_old", pc_old, 32'h20);
        // pc_load while presenting the instruction takes effect at once
        pc_load = 1; pc_target = 32'h60; step(); pc_load = 0;
        check("t3_done_load", pc, 32'h60);
        // Stray ready in IDLE must be ignored
        imem_ready = 1; imem_rdata = 32'hDEAD_BEEF; step(); imem_ready = 0;
        check("t3_stray_ready", inst, 32'hBBBB_0002);

        // Misaligned fetch fault
        pc_load = 1; pc_target = 32'h102; step(); pc_load = 0;
        fetch_req = 1; step(); fetch_req = 0;
        check("t4_fault", {31'd0, fault}, 32'd1);
        check("t4_no_req", {31'd0, imem_req}, 32'd0);
        fetch_req = 1; step(); fetch_req = 0;
        check("t4_fetch_ignored", {31'd0, imem_req}, 32'd0);
        pc_load = 1; pc_target = 32'h103; step(); pc_load = 0;
        check("t4_still_fault", {31'd0, fault}, 32'd1);
        check("t4_pc_kept", pc, 32'h102);
        pc_load = 1; pc_target = 32'h104; step(); pc_load = 0;
        check("t4_cleared", {31'd0, fault}, 32'd0);
        check("t4_pc104", pc, 32'h104);
        fetch_req = 1; step(); fetch_req = 0;
        check("t4_addr", imem_addr, 32'h104);
        imem_ready = 1; imem_rdata = 32'hCCCC_0003; step(); imem_ready = 0;
        step();

        // PC wrap
        pc_load = 1; pc_target = 32'hFFFF_FFFC; step(); pc_load = 0;
        fetch_req = 1; step(); fetch_req = 0;
        imem_ready = 1; imem_rdata = 32'hDDDD_0004; step(); imem_ready = 0;
        check("t5_pc_wrap", pc, 32'h0);
        check("t5_pc_old", pc_old, 32'hFFFF_FFFC);
        step();

        // Reset mid-WAIT, late ready after release
        fetch_req = 1; step(); fetch_req = 0;
        step();
        #2 rst_n = 0;
        #1;
        check("t6_rst_pc", pc, RESET_PC);
        check("t6_rst_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        v0 = val_cnt;
        rst_n = 1;
        imem_ready = 1; imem_rdata = 32'hEEEE_0005; step(); imem_ready = 0;
        check("t6_inst", inst, NOP_INST);
        check("t6_pc", pc, RESET_PC);
        check("t6_no_valid", {31'd0, inst_valid}, 32'd0);
        step(); step();
        check("t6_valid_pulses", val_cnt - v0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
